// File: rtl/isa_pkg.sv
// ISA definitions shared by the sequencer and its decoder: opcodes, ALU selects,
// instruction field positions and the control FSM state encoding.
package isa_pkg;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpNot  = 4'b0010;
  localparam logic [3:0] OpAnd  = 4'b0011;
  localparam logic [3:0] OpOr   = 4'b0100;
  localparam logic [3:0] OpBz   = 4'b0110;
  localparam logic [3:0] OpBn   = 4'b0111;
  localparam logic [3:0] OpJmp  = 4'b1000;
  localparam logic [3:0] OpHalt = 4'b1111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluNot = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluOr  = 3'b100;

  localparam int unsigned OpcodeHi = 15;
  localparam int unsigned OpcodeLo = 12;
  localparam int unsigned RdHi     = 11;
  localparam int unsigned RdLo     = 9;
  localparam int unsigned Rs1Hi    = 8;
  localparam int unsigned Rs1Lo    = 6;
  localparam int unsigned Rs2Hi    = 5;
  localparam int unsigned Rs2Lo    = 3;
  localparam int unsigned OffHi    = 8;
  localparam int unsigned OffLo    = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    CondZero,
    CondNeg,
    CondAlways
  } br_cond_e;

  function automatic logic [15:0] sext_off9(input logic [8:0] off);
    return {{7{off[8]}}, off};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: ALU select plus instruction-class flags.
module instr_decoder
  import isa_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_ctl,
  output logic       is_alu,
  output logic       is_branch,
  output br_cond_e   br_cond,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    alu_ctl    = AluAdd;
    is_alu     = 1'b0;
    is_branch  = 1'b0;
    br_cond    = CondAlways;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    unique case (opcode)
      OpAdd:  begin is_alu = 1'b1; alu_ctl = AluAdd; end
      OpSub:  begin is_alu = 1'b1; alu_ctl = AluSub; end
      OpNot:  begin is_alu = 1'b1; alu_ctl = AluNot; end
      OpAnd:  begin is_alu = 1'b1; alu_ctl = AluAnd; end
      OpOr:   begin is_alu = 1'b1; alu_ctl = AluOr;  end
      OpBz:   begin is_branch = 1'b1; br_cond = CondZero; end
      OpBn:   begin is_branch = 1'b1; br_cond = CondNeg;  end
      OpJmp:  begin is_branch = 1'b1; br_cond = CondAlways; end
      OpHalt: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetch over req/ack, decode, drive ALU and register file,
// and resolve branches from registered ALU flags.
module alu_sequencer
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  output logic [2:0]  rf_raddr1,
  output logic [2:0]  rf_raddr2,
  output logic [2:0]  rf_waddr,
  output logic        rf_we,
  output logic [2:0]  alu_control,
  output logic        upd_flag,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  alu_ctl_q, alu_ctl_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_n_q, flag_n_d;

  logic [2:0]  dec_alu_ctl;
  logic        dec_is_alu;
  logic        dec_is_branch;
  br_cond_e    dec_br_cond;
  logic        dec_is_halt;
  logic        dec_is_illegal;
  logic        br_taken;

  instr_decoder u_instr_decoder (
    .opcode     (ir_q[OpcodeHi:OpcodeLo]),
    .alu_ctl    (dec_alu_ctl),
    .is_alu     (dec_is_alu),
    .is_branch  (dec_is_branch),
    .br_cond    (dec_br_cond),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

  always_comb begin
    br_taken = 1'b0;
    unique case (dec_br_cond)
      CondZero:   br_taken = flag_z_q;
      CondNeg:    br_taken = flag_n_q;
      CondAlways: br_taken = 1'b1;
      default:    br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_ctl_d = alu_ctl_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = instr;
          pc_d    = pc_q + 16'd1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Load the select here so it is a registered value throughout EXECUTE.
        if (dec_is_alu) alu_ctl_d = dec_alu_ctl;
        state_d = dec_is_halt ? StHalt : StExecute;
      end
      StExecute: begin
        if (dec_is_alu) begin
          flag_z_d = alu_zero;
          flag_n_d = alu_neg;
          state_d  = StWriteback;
        end else begin
          // pc already points past the branch, so the target is relative to pc+1.
          if (dec_is_branch && br_taken) begin
            pc_d = pc_q + sext_off9(ir_q[OffHi:OffLo]);
          end
          state_d = StFetch;
        end
      end
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      alu_ctl_q <= AluAdd;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_ctl_q <= alu_ctl_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
    end
  end

  assign pc          = pc_q;
  assign rf_raddr1   = ir_q[Rs1Hi:Rs1Lo];
  assign rf_raddr2   = ir_q[Rs2Hi:Rs2Lo];
  assign rf_waddr    = ir_q[RdHi:RdLo];
  assign alu_control = alu_ctl_q;
  assign imem_req    = (state_q == StFetch);
  assign rf_we       = (state_q == StWriteback);
  assign upd_flag    = (state_q == StExecute) && dec_is_alu;
  assign illegal     = (state_q == StExecute) && dec_is_illegal;
  assign busy        = (state_q != StIdle) && (state_q != StHalt);
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: imem and ALU flags are driven by hand,
// every expected value is hand-computed.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;
  logic        imem_req;
  logic [15:0] pc;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we;
  logic [2:0]  alu_control;
  logic        upd_flag, busy, halted, illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .pc          (pc),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .alu_control (alu_control),
    .upd_flag    (upd_flag),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in a FETCH cycle; leaves the DUT in DECODE.
  task automatic fetch(input logic [15:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", {15'd0, imem_req}, 16'd1);
      tick();
    end
    chk("req", {15'd0, imem_req}, 16'd1);
    imem_ack = 1'b1;
    instr    = w;
    tick();
    imem_ack = 1'b0;
    instr    = 16'hDEAD;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);
    chk("rst_we", {15'd0, rf_we}, 16'd0);
    chk("rst_upd", {15'd0, upd_flag}, 16'd0);
    chk("rst_aluctl", {13'd0, alu_control}, 16'd0);
    chk("rst_raddr1", {13'd0, rf_raddr1}, 16'd0);
    chk("rst_raddr2", {13'd0, rf_raddr2}, 16'd0);
    chk("rst_waddr", {13'd0, rf_waddr}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_req", {15'd0, imem_req}, 16'd0);

    // ADD r3 <- r1, r2 with zero-wait ack
    start = 1'b1; tick(); start = 1'b0;
    chk("add_busy", {15'd0, busy}, 16'd1);
    fetch(16'h0650, 0);
    chk("add_dec_pc", pc, 16'h0001);
    chk("add_raddr1", {13'd0, rf_raddr1}, 16'd1);
    chk("add_raddr2", {13'd0, rf_raddr2}, 16'd2);
    chk("add_dec_upd", {15'd0, upd_flag}, 16'd0);
    tick();
    chk("add_ex_upd", {15'd0, upd_flag}, 16'd1);
    chk("add_ex_aluctl", {13'd0, alu_control}, 16'd0);
    chk("add_ex_we", {15'd0, rf_we}, 16'd0);
    tick();
    chk("add_wb_we", {15'd0, rf_we}, 16'd1);
    chk("add_wb_waddr", {13'd0, rf_waddr}, 16'd3);
    chk("add_wb_upd", {15'd0, upd_flag}, 16'd0);
    tick();
    chk("add_next_we", {15'd0, rf_we}, 16'd0);
    chk("add_next_req", {15'd0, imem_req}, 16'd1);

    // JMP +2 at pc=1, with start held high (ignored outside IDLE)
    start = 1'b1;
    fetch(16'h8002, 0);
    start = 1'b0;
    tick();
    chk("jmp_ex_upd", {15'd0, upd_flag}, 16'd0);
    tick();
    chk("jmp_pc", pc, 16'h0004);
    chk("jmp_req", {15'd0, imem_req}, 16'd1);

    // SUB r0 <- r4, r4 giving zero, then BZ -2 at pc=5
    fetch(16'h1120, 0);
    chk("sub_dec_pc", pc, 16'h0005);
    alu_zero = 1'b1; alu_neg = 1'b0;
    tick();
    chk("sub_ex_aluctl", {13'd0, alu_control}, 16'd1);
    chk("sub_ex_upd", {15'd0, upd_flag}, 16'd1);
    tick();
    alu_zero = 1'b0;
    chk("sub_wb_waddr", {13'd0, rf_waddr}, 16'd0);
    chk("sub_wb_aluctl", {13'd0, alu_control}, 16'd1);
    tick();
    fetch(16'h61FE, 0);
    chk("bz1_dec_pc", pc, 16'h0006);
    tick();
    chk("bz1_ex_upd", {15'd0, upd_flag}, 16'd0);
    tick();
    chk("bz_taken_pc", pc, 16'h0004);

    // OR r5 <- r6, r7 giving nonzero/negative; ack held outside FETCH is ignored
    fetch(16'h4BB8, 0);
    imem_ack = 1'b1; instr = 16'h0000;
    chk("or_raddr1", {13'd0, rf_raddr1}, 16'd6);
    chk("or_raddr2", {13'd0, rf_raddr2}, 16'd7);
    alu_zero = 1'b0; alu_neg = 1'b1;
    tick();
    chk("or_ex_aluctl", {13'd0, alu_control}, 16'd4);
    chk("or_ex_pc", pc, 16'h0005);
    chk("or_ex_raddr1", {13'd0, rf_raddr1}, 16'd6);
    tick();
    imem_ack = 1'b0; alu_neg = 1'b0;
    chk("or_wb_we", {15'd0, rf_we}, 16'd1);
    chk("or_wb_waddr", {13'd0, rf_waddr}, 16'd5);
    chk("or_wb_pc", pc, 16'h0005);
    tick();

    // BZ not taken (flag_z now 0)
    fetch(16'h61FE, 0);
    tick(); tick();
    chk("bz_not_taken_pc", pc, 16'h0006);

    // BN +3 at pc=6: taken since OR set flag_n
    fetch(16'h7003, 0);
    tick(); tick();
    chk("bn_taken_pc", pc, 16'h000A);

    // JMP -12 at pc=10 wraps below zero to 0xFFFF
    fetch(16'h81F4, 0);
    tick(); tick();
    chk("jmp_neg_wrap_pc", pc, 16'hFFFF);

    // JMP +1 at pc=0xFFFF: increment wraps to 0, target is 1
    fetch(16'h8001, 0);
    chk("pc_inc_wrap", pc, 16'h0000);
    tick(); tick();
    chk("jmp_wrap_pc", pc, 16'h0001);

    // Illegal opcode 1010
    fetch(16'hA000, 0);
    chk("ill_dec", {15'd0, illegal}, 16'd0);
    tick();
    chk("ill_ex", {15'd0, illegal}, 16'd1);
    chk("ill_ex_upd", {15'd0, upd_flag}, 16'd0);
    chk("ill_ex_we", {15'd0, rf_we}, 16'd0);
    tick();
    chk("ill_after", {15'd0, illegal}, 16'd0);
    chk("ill_after_we", {15'd0, rf_we}, 16'd0);
    chk("ill_after_pc", pc, 16'h0002);
    chk("ill_after_req", {15'd0, imem_req}, 16'd1);

    // NOT r1 <- r2 with ack delayed 3 cycles
    fetch(16'h2280, 3);
    chk("not_dec_pc", pc, 16'h0003);
    chk("not_dec_req", {15'd0, imem_req}, 16'd0);
    tick();
    chk("not_ex_aluctl", {13'd0, alu_control}, 16'd2);
    tick();
    chk("not_wb_we", {15'd0, rf_we}, 16'd1);
    chk("not_wb_waddr", {13'd0, rf_waddr}, 16'd1);
    tick();
    chk("not_hold_aluctl", {13'd0, alu_control}, 16'd2);
    chk("not_next_req", {15'd0, imem_req}, 16'd1);

    // AND r7 <- r1, r1 (sets flag_z), then reset during WRITEBACK
    fetch(16'h3E48, 0);
    alu_zero = 1'b1;
    tick();
    chk("and_ex_aluctl", {13'd0, alu_control}, 16'd3);
    tick();
    alu_zero = 1'b0;
    chk("and_wb_we", {15'd0, rf_we}, 16'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_we", {15'd0, rf_we}, 16'd0);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_aluctl", {13'd0, alu_control}, 16'd0);
    chk("mid_rst_waddr", {13'd0, rf_waddr}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", {15'd0, imem_req}, 16'd0);
    chk("post_rst_we", {15'd0, rf_we}, 16'd0);

    // Flags cleared by reset: BZ +5 at pc=0 not taken
    start = 1'b1; tick(); start = 1'b0;
    fetch(16'h6005, 0);
    tick(); tick();
    chk("bz_after_rst_pc", pc, 16'h0001);

    // HALT at pc=1
    fetch(16'hF000, 0);
    chk("halt_dec_busy", {15'd0, busy}, 16'd1);
    chk("halt_dec_halted", {15'd0, halted}, 16'd0);
    tick();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_busy", {15'd0, busy}, 16'd0);
    chk("halt_req", {15'd0, imem_req}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; tick(); start = 1'b0; tick();
      chk("halt_start_req", {15'd0, imem_req}, 16'd0);
    end
    chk("halt_stays", {15'd0, halted}, 16'd1);
    chk("halt_pc", pc, 16'h0002);
    rst_n = 1'b0;
    tick();
    chk("halt_rst_halted", {15'd0, halted}, 16'd0);
    chk("halt_rst_pc", pc, 16'h0000);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
